// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - md_op_e     : 3-bit operation codes presented on the Op port
//   - md_state_e  : control states of the unit (IDLE / BUSY)
//   - default latency constants for multiply and divide
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDOP_MULT  = 3'd0,
    MDOP_MULTU = 3'd1,
    MDOP_DIV   = 3'd2,
    MDOP_DIVU  = 3'd3,
    MDOP_MTHI  = 3'd4,
    MDOP_MTLO  = 3'd5,
    MDOP_NOP6  = 3'd6,
    MDOP_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // True for the four opcodes that go through the multi-cycle path.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MDOP_MULT) || (op == MDOP_MULTU) ||
           (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_core.sv
// -----------------------------------------------------------------------------
// md_core
// Purely combinational arithmetic core. Produces the {hi, lo} pair for
// mult, multu, div and divu; other opcodes yield zero (unused by the top).
//   op_i  : operation code
//   a_i   : operand rs (dividend / multiplicand)
//   b_i   : operand rt (divisor / multiplier)
//   hi_o  : upper product half, or remainder
//   lo_o  : lower product half, or quotient
// Division by zero gives lo = all ones, hi = dividend.
// Signed overflow (most-negative / -1) gives lo = dividend, hi = 0.
// -----------------------------------------------------------------------------
module md_core
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quot_u;
  logic [WIDTH-1:0]   rem_u;
  logic               div_zero;
  logic               div_ovf;

  // Sign-extending both operands to 2*WIDTH makes an unsigned multiply
  // produce the correct two's-complement signed product in 2*WIDTH bits.
  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Signed / and % truncate toward zero; remainder follows the dividend.
  assign quot_s = $signed(a_i) / $signed(b_i);
  assign rem_s  = $signed(a_i) % $signed(b_i);
  assign quot_u = a_i / b_i;
  assign rem_u  = a_i % b_i;

  assign div_zero = (b_i == '0);
  assign div_ovf  = (a_i == MOST_NEG) && (b_i == MINUS_ONE);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MDOP_MULT: begin
        hi_o = prod_s[2*WIDTH-1:WIDTH];
        lo_o = prod_s[WIDTH-1:0];
      end
      MDOP_MULTU: begin
        hi_o = prod_u[2*WIDTH-1:WIDTH];
        lo_o = prod_u[WIDTH-1:0];
      end
      MDOP_DIV: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = MINUS_ONE;
        end else if (div_ovf) begin
          hi_o = '0;
          lo_o = a_i;
        end else begin
          hi_o = rem_s;
          lo_o = quot_s;
        end
      end
      MDOP_DIVU: begin
        if (div_zero) begin
          hi_o = a_i;
          lo_o = MINUS_ONE;
        end else begin
          hi_o = rem_u;
          lo_o = quot_u;
        end
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result of mult/multu/div/divu is computed when the operation is
// accepted and held in pending registers; HI/LO only change when the
// latency counter expires, so the visible timing matches an iterative unit.
//   clk   : system clock
//   reset : synchronous active-high reset (aborts any operation in flight)
//   start : request strobe; ignored while busy
//   Op    : operation code (see mult_div_unit_pkg::md_op_e)
//   A, B  : operands rs / rt
//   busy  : high for exactly MULT_CYCLES / DIV_CYCLES cycles per operation
//   done  : one-cycle pulse in the first cycle after the HI/LO commit
//   HI,LO : architectural result registers
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] core_hi_d;
  logic [WIDTH-1:0] core_lo_d;

  md_core #(
    .WIDTH (WIDTH)
  ) u_md_core (
    .op_i (Op),
    .a_i  (A),
    .b_i  (B),
    .hi_o (core_hi_d),
    .lo_o (core_lo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_arith_op(Op)) begin
              pend_hi_q <= core_hi_d;
              pend_lo_q <= core_lo_d;
              cnt_q     <= (Op == MDOP_MULT || Op == MDOP_MULTU) ? MULT_LOAD : DIV_LOAD;
              busy_q    <= 1'b1;
              state_q   <= ST_BUSY;
            end else if (Op == MDOP_MTHI) begin
              hi_q <= A;
            end else if (Op == MDOP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        ST_BUSY: begin
          // start is deliberately not looked at here: the pipeline stalls.
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench: directed cases followed by randomized operations,
// all compared against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W  = 32;
  localparam int NM = 5;
  localparam int ND = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit #(
    .WIDTH       (W),
    .MULT_CYCLES (NM),
    .DIV_CYCLES  (ND),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Op    (Op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {hi, lo} straight from 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    int     sa, sb;
    longint la, lb, q, r;
    logic [63:0] res;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    res = '0;
    case (op)
      3'd0: res = la * lb;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          // In 64 bits -2^31 / -1 = +2^31, whose low word is 0x80000000.
          q = la / lb;
          r = la % lb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else        res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation starting #1 after a rising edge. For arithmetic ops
  // the busy window is measured; inject drives a mult 2x2 start mid-flight;
  // tail waits one more cycle to confirm done is a single pulse.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit inject, input bit tail);
    logic [63:0] exp;
    int n, cnt;
    start = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    if (op <= 3'd3) begin
      exp = ref_result(op, a, b);
      n   = (op <= 3'd1) ? NM : ND;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
        if (inject && cnt == 1) begin
          start = 1'b1; Op = 3'd0; A = 32'd2; B = 32'd2;
        end else begin
          start = 1'b0;
        end
        cnt++;
        @(posedge clk); #1;
      end
      start = 1'b0;
      check_eq("busy_len", 64'(cnt), 64'(n));
      check_eq("hi", {32'd0, HI}, {32'd0, exp[63:32]});
      check_eq("lo", {32'd0, LO}, {32'd0, exp[31:0]});
      check_eq("done_pulse", {63'd0, done}, 64'd1);
      model_hi = exp[63:32];
      model_lo = exp[31:0];
      if (tail) begin
        @(posedge clk); #1;
        check_eq("done_clear", {63'd0, done}, 64'd0);
        check_eq("busy_clear", {63'd0, busy}, 64'd0);
      end
    end else begin
      if (op == 3'd4) model_hi = a;
      if (op == 3'd5) model_lo = a;
      check_eq("single_busy", {63'd0, busy}, 64'd0);
      check_eq("single_done", {63'd0, done}, 64'd0);
      check_eq("single_hi", {32'd0, HI}, {32'd0, model_hi});
      check_eq("single_lo", {32'd0, LO}, {32'd0, model_lo});
    end
    $display("op=%0d A=%08h B=%08h -> HI=%08h LO=%08h", op, a, b, HI, LO);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset and start together: reset wins.
    start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_hi", {32'd0, HI}, 64'd0);
    check_eq("rst_lo", {32'd0, LO}, 64'd0);
    @(posedge clk); #1;

    // Directed cases.
    issue(3'd0, 32'hFFFF_FFFE, 32'd3,        1'b0, 1'b1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2,        1'b0, 1'b0);
    issue(3'd3, 32'd7,         32'd2,        1'b0, 1'b1);
    issue(3'd2, 32'd5,         32'd0,        1'b0, 1'b0);
    issue(3'd3, 32'd5,         32'd0,        1'b0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check_eq("ovf_lo_const", {32'd0, LO}, 64'h8000_0000);
    issue(3'd4, 32'h1234_5678, 32'd0,        1'b0, 1'b0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0,        1'b0, 1'b0);
    issue(3'd6, 32'h5555_5555, 32'd1,        1'b0, 1'b0);
    issue(3'd0, 32'd1234,      32'd5678,     1'b1, 1'b1);

    // Reset in the 3rd busy cycle of a mult aborts it.
    start = 1'b1; Op = 3'd0; A = 32'd100; B = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_hi", {32'd0, HI}, 64'd0);
    check_eq("abort_lo", {32'd0, LO}, 64'd0);
    check_eq("abort_done", {63'd0, done}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_done", {63'd0, done}, 64'd0);
    end
    issue(3'd3, 32'd9, 32'd4, 1'b0, 1'b1);

    // Randomized, mostly back-to-back.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      issue(rop, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule
